// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared defaults, chunk width and FSM state encoding for the chunked subtractor
package cla_pkg;

   localparam int CLA_WIDTH   = 51;
   localparam int CLA_NCHUNK  = 3;
   localparam int CLA_CHUNK_W = CLA_WIDTH / CLA_NCHUNK;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_NEG  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/sub_chunk.sv
// rtl/sub_chunk.sv - combinational chunk subtract with borrow in/out
module sub_chunk #(
   parameter int CW = 17
) (
   input  logic [CW-1:0] a_i,
   input  logic [CW-1:0] b_i,
   input  logic          bin_i,
   output logic [CW-1:0] diff_o,
   output logic          bout_o
);

   logic [CW:0] full;

   // The extra top bit wraps to 1 exactly when the chunk borrows.
   assign full   = {1'b0, a_i} - {1'b0, b_i} - {{CW{1'b0}}, bin_i};
   assign diff_o = full[CW-1:0];
   assign bout_o = full[CW];

endmodule

// File: rtl/cla_sub_seq_51bit.sv
// rtl/cla_sub_seq_51bit.sv - sequential chunked subtractor; CLA_SUB_MAG_OUT_EN selects magnitude output
module cla_sub_seq_51bit
   import cla_pkg::*;
#(
   parameter int WIDTH  = CLA_WIDTH,
   parameter int NCHUNK = CLA_NCHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             borrow
);

   localparam int CW    = WIDTH / NCHUNK;
   localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, d_q, d_d;
   logic               res_borrow_q, res_borrow_d;
   logic               brw_q, brw_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               last_chunk;
   logic [CW-1:0]      sc_a, sc_b, sc_diff;
   logic               sc_bin, sc_bout;
`ifdef CLA_SUB_MAG_OUT_EN
   logic               carry_q, carry_d;
`endif

   assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

   // Operands shift right one chunk per cycle so the datapath always reads the low chunk.
   always_comb begin
      sc_a   = a_q[CW-1:0];
      sc_b   = b_q[CW-1:0];
      sc_bin = brw_q;
`ifdef CLA_SUB_MAG_OUT_EN
      // ~x + c is computed as 0 - x - ~c, so carry-out is the inverted borrow-out.
      if (state_q == ST_NEG) begin
         sc_a   = '0;
         sc_b   = d_q[CW-1:0];
         sc_bin = ~carry_q;
      end
`endif
   end

   sub_chunk #(.CW(CW)) u_sub_chunk (
      .a_i    (sc_a),
      .b_i    (sc_b),
      .bin_i  (sc_bin),
      .diff_o (sc_diff),
      .bout_o (sc_bout)
   );

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      d_d          = d_q;
      res_borrow_d = res_borrow_q;
      brw_d        = brw_q;
      cnt_d        = cnt_q;
`ifdef CLA_SUB_MAG_OUT_EN
      carry_d      = carry_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d          = a;
               b_d          = b;
               brw_d        = 1'b0;
               cnt_d        = '0;
               res_borrow_d = 1'b0;
               state_d      = ST_SUB;
            end
         end
         ST_SUB: begin
            d_d   = {sc_diff, d_q[WIDTH-1:CW]};
            a_d   = a_q >> CW;
            b_d   = b_q >> CW;
            brw_d = sc_bout;
            cnt_d = last_chunk ? '0 : cnt_q + CNT_W'(1);
            if (last_chunk) begin
               res_borrow_d = sc_bout;
               state_d      = ST_DONE;
`ifdef CLA_SUB_MAG_OUT_EN
               if (sc_bout) begin
                  carry_d = 1'b1;
                  state_d = ST_NEG;
               end
`endif
            end
         end
`ifdef CLA_SUB_MAG_OUT_EN
         ST_NEG: begin
            d_d     = {sc_diff, d_q[WIDTH-1:CW]};
            carry_d = ~sc_bout;
            cnt_d   = last_chunk ? '0 : cnt_q + CNT_W'(1);
            if (last_chunk) state_d = ST_DONE;
         end
`endif
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         d_q          <= '0;
         res_borrow_q <= 1'b0;
         brw_q        <= 1'b0;
         cnt_q        <= '0;
`ifdef CLA_SUB_MAG_OUT_EN
         carry_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         d_q          <= d_d;
         res_borrow_q <= res_borrow_d;
         brw_q        <= brw_d;
         cnt_q        <= cnt_d;
`ifdef CLA_SUB_MAG_OUT_EN
         carry_q      <= carry_d;
`endif
      end
   end

   // Partial chunks never leave the block: d/borrow only show in DONE.
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign d         = out_valid ? d_q : '0;
   assign borrow    = out_valid & res_borrow_q;

endmodule

// File: tb/tb_cla_sub_seq_51bit.sv
// tb/tb_cla_sub_seq_51bit.sv - directed self-checking bench for cla_sub_seq_51bit
module tb_cla_sub_seq_51bit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [50:0] a = '0;
   logic [50:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [50:0] d;
   logic        borrow;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   cla_sub_seq_51bit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .borrow    (borrow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef CLA_SUB_MAG_OUT_EN
   localparam bit MAG = 1'b1;
`else
   localparam bit MAG = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [50:0] model_d(input logic [50:0] av, input logic [50:0] bv);
      if (MAG && av < bv) return bv - av;
      return av - bv;
   endfunction

   function automatic int model_lat(input logic [50:0] av, input logic [50:0] bv);
      return (MAG && av < bv) ? 6 : 3;
   endfunction

   // Presents one operand pair for a single accept edge and counts edges until out_valid.
   task automatic run_op(input logic [50:0] av, input logic [50:0] bv, output int lat);
      a = av;
      b = bv;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   logic [50:0] va [4];
   logic [50:0] vb [4];

   initial begin
      int lat;
      int prev_cyc;
      int waited;
      logic [50:0] held_d;
      logic        held_b;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_d", 64'(d), 64'd0);
      check("rst_borrow", 64'(borrow), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 100 - 58 with out_ready already high beforehand
      out_ready = 1'b1;
      run_op(51'd100, 51'd58, lat);
      check("basic_lat", 64'(lat), 64'd3);
      check("basic_d", 64'(d), 64'd42);
      check("basic_borrow", 64'(borrow), 64'd0);
      consume();

      // 5 - 7 underflow
      run_op(51'd5, 51'd7, lat);
      check("neg_lat", 64'(lat), MAG ? 64'd6 : 64'd3);
      check("neg_d", 64'(d), MAG ? 64'd2 : 64'h7_FFFF_FFFF_FFFE);
      check("neg_borrow", 64'(borrow), 64'd1);
      consume();
      check("idle_after_consume", 64'(in_ready), 64'd1);

      // Borrow ripples across chunks 0 and 1
      run_op(51'h4_0000_0000, 51'd1, lat);
      check("xchunk_lat", 64'(lat), 64'd3);
      check("xchunk_d", 64'(d), 64'h3_FFFF_FFFF);
      check("xchunk_borrow", 64'(borrow), 64'd0);

      // Hold in DONE with a competing in_valid
      held_d = d;
      held_b = borrow;
      a = 51'd1;
      b = 51'd0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_d", 64'(d), 64'(held_d));
         check("hold_borrow", 64'(borrow), 64'(held_b));
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_out_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      consume();
      check("post_hold_out_valid", 64'(out_valid), 64'd0);
      check("post_hold_in_ready", 64'(in_ready), 64'd1);

      // Reset during SUB chunk 1
      a = 51'd1000;
      b = 51'd1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_d", 64'(d), 64'd0);
      check("midrst_borrow", 64'(borrow), 64'd0);
      @(posedge clk); #1;
      check("after_rst_out_valid", 64'(out_valid), 64'd0);
      run_op(51'h7_FFFF_FFFF_FFFF, 51'h7_FFFF_FFFF_FFFF, lat);
      check("eq_lat", 64'(lat), 64'd3);
      check("eq_d", 64'(d), 64'd0);
      check("eq_borrow", 64'(borrow), 64'd0);
      consume();

      // Back-to-back with in_valid and out_ready held high
      va[0] = 51'h7_FFFF_FFFF_FFFF; vb[0] = 51'd1;
      va[1] = 51'd0;                vb[1] = 51'd1;
      va[2] = 51'h1_FFFF;           vb[2] = 51'h2_0000;
      va[3] = 51'd12345;            vb[3] = 51'd12345;
      a = va[0];
      b = vb[0];
      out_ready = 1'b1;
      in_valid = 1'b1;
      prev_cyc = 0;
      for (int i = 0; i < 4; i++) begin
         waited = 0;
         while (!out_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
         end
         check("b2b_valid", 64'(out_valid), 64'd1);
         check("b2b_d", 64'(d), 64'(model_d(va[i], vb[i])));
         check("b2b_borrow", 64'(borrow), 64'(va[i] < vb[i]));
         if (i > 0) check("b2b_period", 64'(cyc - prev_cyc), 64'(model_lat(va[i], vb[i]) + 2));
         prev_cyc = cyc;
         if (i < 3) begin
            a = va[i+1];
            b = vb[i+1];
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
